// File: rtl/crc_ctrl_pkg.sv
// Shared types and constants for the CRC arbiter and its register front-end.
package crc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned BEAT_CNT_W     = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Beat counter increment that sticks at all-ones.
    function automatic logic [BEAT_CNT_W-1:0] sat_inc(input logic [BEAT_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + BEAT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/crc_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any
);

    logic [IDX_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((32'(ptr) + 32'(k)) % NUM_REQ);
            if (req[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crc_arbiter.sv
// Shares one combinational CRC engine among NUM_REQ packet requesters,
// arbitrating round-robin per packet and returning one result per packet.
module crc_arbiter
    import crc_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_seed,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         crc_initial,
    output logic [DATA_WIDTH-1:0]         crc_data,
    input  logic [DATA_WIDTH-1:0]         crc_result,
    output logic                          res_valid,
    output logic [IDX_W-1:0]              res_id,
    output logic [DATA_WIDTH-1:0]         res_crc,
    output logic [BEAT_CNT_W-1:0]         res_beats,
    input  logic                          res_ready,
    output logic                          busy
);

    state_t                  state;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        grant;
    logic [IDX_W-1:0]        pick;
    logic                    any_req;
    logic [DATA_WIDTH-1:0]   running;
    logic [BEAT_CNT_W-1:0]   beat_cnt;
    logic [BEAT_CNT_W-1:0]   next_cnt;
    logic [IDX_W-1:0]        next_ptr;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]   seed_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign seed_arr[i] = req_seed[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick),
        .any   (any_req)
    );

    assign accept      = (state == BUSY) && req_valid[grant];
    assign next_cnt    = sat_inc(beat_cnt);
    assign next_ptr    = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
    assign crc_initial = running;
    assign crc_data    = (state == BUSY) ? data_arr[grant] : '0;
    assign busy        = (state != IDLE);

    // Only the granted requester sees ready, and only while its packet is open.
    always_comb begin
        req_ready = '0;
        if (state == BUSY) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            running   <= '0;
            beat_cnt  <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_crc   <= '0;
            res_beats <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant    <= pick;
                        running  <= seed_arr[pick];
                        beat_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        running  <= crc_result;
                        beat_cnt <= next_cnt;
                        if (req_last[grant]) begin
                            res_crc   <= crc_result;
                            res_id    <= grant;
                            res_beats <= next_cnt;
                            res_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        rr_ptr    <= next_ptr;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_arbiter.sv
// Self-checking bench for crc_arbiter with an XOR engine stub and a packet-level model.
module tb_crc_arbiter;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned DW        = 32;
    localparam int unsigned IW        = 2;
    localparam int          MAX_BEATS = 8;

    logic                    ACLK = 1'b0;
    logic                    ARESET;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*DW-1:0]   req_data;
    logic [NUM_REQ-1:0]      req_last;
    logic [NUM_REQ*DW-1:0]   req_seed;
    logic [NUM_REQ-1:0]      req_ready;
    logic [DW-1:0]           crc_initial;
    logic [DW-1:0]           crc_data;
    logic [DW-1:0]           crc_result;
    logic                    res_valid;
    logic [IW-1:0]           res_id;
    logic [DW-1:0]           res_crc;
    logic [15:0]             res_beats;
    logic                    res_ready;
    logic                    busy;

    logic          tb_valid [NUM_REQ];
    logic          tb_last  [NUM_REQ];
    logic [DW-1:0] tb_data  [NUM_REQ];
    logic [DW-1:0] tb_seed  [NUM_REQ];
    logic [DW-1:0] pkt_seed [NUM_REQ];
    logic [DW-1:0] pkt_mem  [NUM_REQ][MAX_BEATS];

    int n_checks;
    int n_pass;

    always #5 ACLK = ~ACLK;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_drv
        assign req_valid[g]            = tb_valid[g];
        assign req_last[g]             = tb_last[g];
        assign req_data[g*DW +: DW]    = tb_data[g];
        assign req_seed[g*DW +: DW]    = tb_seed[g];
    end

    assign crc_result = crc_initial ^ crc_data;

    crc_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_seed    (req_seed),
        .req_ready   (req_ready),
        .crc_initial (crc_initial),
        .crc_data    (crc_data),
        .crc_result  (crc_result),
        .res_valid   (res_valid),
        .res_id      (res_id),
        .res_crc     (res_crc),
        .res_beats   (res_beats),
        .res_ready   (res_ready),
        .busy        (busy)
    );

    // Packet CRC under the XOR engine: seed folded with every data word.
    function automatic logic [DW-1:0] model_crc(input int r, input int len);
        logic [DW-1:0] c;
        c = pkt_seed[r];
        for (int i = 0; i < len; i++) c = c ^ pkt_mem[r][i];
        return c;
    endfunction

    task automatic fill_pkt(input int r);
        pkt_seed[r] = $urandom;
        for (int b = 0; b < MAX_BEATS; b++) pkt_mem[r][b] = $urandom;
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESET    = 1'b1;
        res_ready = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            tb_valid[r] = 1'b0;
            tb_last[r]  = 1'b0;
        end
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
    endtask

    // Present one packet on requester r; valid drops for stall_len cycles when beat stall_at is due.
    task automatic drive_pkt(input int r, input int len, input int stall_at, input int stall_len,
                             output bit to);
        int sent;
        int cyc;
        int stalled;
        bit acc;
        bit stall_now;
        sent = 0; cyc = 0; stalled = 0; to = 1'b0;
        tb_seed[r] = pkt_seed[r];
        while (sent < len && !to) begin
            stall_now   = (sent == stall_at) && (stalled < stall_len);
            tb_valid[r] = !stall_now;
            tb_data[r]  = pkt_mem[r][sent];
            tb_last[r]  = (sent == len - 1);
            if (stall_now) stalled++;
            acc = !stall_now && req_ready[r];
            @(posedge ACLK);
            if (acc) sent++;
            cyc++;
            if (cyc > 300) to = 1'b1;
            @(negedge ACLK);
        end
        tb_valid[r] = 1'b0;
        tb_last[r]  = 1'b0;
    endtask

    // Wait for a result, hold res_ready low for `hold` cycles, then handshake.
    task automatic wait_result(input int hold, output logic [IW-1:0] id, output logic [DW-1:0] crc,
                               output logic [15:0] beats, output bit to);
        int cyc;
        cyc = 0; to = 1'b0; id = '0; crc = '0; beats = '0;
        while (!res_valid && cyc < 400) begin
            @(negedge ACLK);
            cyc++;
        end
        if (!res_valid) begin
            to = 1'b1;
            return;
        end
        id = res_id; crc = res_crc; beats = res_beats;
        repeat (hold) @(negedge ACLK);
        res_ready = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        for (int r = 0; r < NUM_REQ; r++) begin
            tb_valid[r] = 1'b1;
            tb_data[r]  = $urandom;
            tb_seed[r]  = $urandom;
        end
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
        n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b exp 0", res_valid); else n_pass++;
        n_checks++; if (req_ready !== 4'b0) $display("FAIL reset_req_ready: got %b exp 0000", req_ready); else n_pass++;
        n_checks++; if (res_id !== 2'd0) $display("FAIL reset_res_id: got %0d exp 0", res_id); else n_pass++;
        n_checks++; if (res_crc !== 32'h0) $display("FAIL reset_res_crc: got %h exp 0", res_crc); else n_pass++;
        n_checks++; if (res_beats !== 16'h0) $display("FAIL reset_res_beats: got %h exp 0", res_beats); else n_pass++;
        n_checks++; if (crc_initial !== 32'h0) $display("FAIL reset_crc_initial: got %h exp 0", crc_initial); else n_pass++;
        n_checks++; if (crc_data !== 32'h0) $display("FAIL reset_crc_data: got %h exp 0", crc_data); else n_pass++;
        for (int r = 0; r < NUM_REQ; r++) tb_valid[r] = 1'b0;
        ARESET = 1'b0;
    endtask

    task automatic test_basic();
        bit to; bit rto;
        logic [IW-1:0] gid; logic [DW-1:0] gcrc; logic [15:0] gbeats;
        do_reset();
        pkt_seed[0]   = 32'hFFFF_FFFF;
        pkt_mem[0][0] = 32'h1234_5678;
        pkt_mem[0][1] = 32'h0000_FFFF;
        fork
            drive_pkt(0, 2, -1, 0, to);
            wait_result(0, gid, gcrc, gbeats, rto);
        join
        n_checks++; if (to || rto) $display("FAIL basic_timeout: got drv=%b res=%b exp 0 0", to, rto); else n_pass++;
        n_checks++; if (gcrc !== 32'hEDCB_5678) $display("FAIL basic_crc: got %h exp edcb5678", gcrc); else n_pass++;
        n_checks++; if (gid !== 2'd0) $display("FAIL basic_id: got %0d exp 0", gid); else n_pass++;
        n_checks++; if (gbeats !== 16'd2) $display("FAIL basic_beats: got %0d exp 2", gbeats); else n_pass++;
    endtask

    task automatic test_two_req();
        bit to1; bit to2; bit rto_a; bit rto_b;
        logic [IW-1:0] id_a; logic [IW-1:0] id_b;
        logic [DW-1:0] crc_a; logic [DW-1:0] crc_b;
        logic [15:0] bt_a; logic [15:0] bt_b;
        do_reset();
        fill_pkt(1); fill_pkt(2);
        fork
            drive_pkt(1, 2, -1, 0, to1);
            drive_pkt(2, 3, -1, 0, to2);
            begin
                wait_result(1, id_a, crc_a, bt_a, rto_a);
                wait_result(0, id_b, crc_b, bt_b, rto_b);
            end
        join
        n_checks++; if (to1 || to2 || rto_a || rto_b) $display("FAIL two_timeout: got %b%b%b%b exp 0000", to1, to2, rto_a, rto_b); else n_pass++;
        n_checks++; if (id_a !== 2'd1) $display("FAIL two_first_id: got %0d exp 1", id_a); else n_pass++;
        n_checks++; if (crc_a !== model_crc(1, 2)) $display("FAIL two_first_crc: got %h exp %h", crc_a, model_crc(1, 2)); else n_pass++;
        n_checks++; if (id_b !== 2'd2) $display("FAIL two_second_id: got %0d exp 2", id_b); else n_pass++;
        n_checks++; if ({crc_b, bt_b} !== {model_crc(2, 3), 16'd3}) $display("FAIL two_second_crc: got %h/%0d exp %h/3", crc_b, bt_b, model_crc(2, 3)); else n_pass++;
        // Pointer should now sit at 3, so requester 3 beats requester 0.
        fill_pkt(0); fill_pkt(3);
        fork
            drive_pkt(0, 1, -1, 0, to1);
            drive_pkt(3, 1, -1, 0, to2);
            begin
                wait_result(0, id_a, crc_a, bt_a, rto_a);
                wait_result(0, id_b, crc_b, bt_b, rto_b);
            end
        join
        n_checks++; if (rto_a || id_a !== 2'd3) $display("FAIL ptr_after_two: got id %0d exp 3", id_a); else n_pass++;
        n_checks++; if (rto_b || id_b !== 2'd0) $display("FAIL ptr_wrap: got id %0d exp 0", id_b); else n_pass++;
    endtask

    task automatic test_single_beat();
        do_reset();
        tb_seed[3]  = 32'h0;
        tb_data[3]  = 32'hA5A5_A5A5;
        tb_last[3]  = 1'b1;
        tb_valid[3] = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        n_checks++; if ({res_valid, req_ready} !== 5'b0_1000) $display("FAIL single_cycle1: got valid=%b ready=%b exp 0/1000", res_valid, req_ready); else n_pass++;
        @(posedge ACLK);
        @(negedge ACLK);
        tb_valid[3] = 1'b0;
        tb_last[3]  = 1'b0;
        n_checks++; if (res_valid !== 1'b1) $display("FAIL single_cycle2_valid: got %b exp 1", res_valid); else n_pass++;
        n_checks++; if ({res_id, res_crc, res_beats} !== {2'd3, 32'hA5A5_A5A5, 16'd1}) $display("FAIL single_result: got %0d/%h/%0d exp 3/a5a5a5a5/1", res_id, res_crc, res_beats); else n_pass++;
        res_ready = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        res_ready = 1'b0;
        n_checks++; if ({res_valid, busy} !== 2'b00) $display("FAIL single_release: got valid=%b busy=%b exp 0 0", res_valid, busy); else n_pass++;
    endtask

    task automatic test_stall();
        bit to0; bit to3; bit rto_a; bit rto_b; bit done0; bit viol;
        logic [IW-1:0] id_a; logic [IW-1:0] id_b;
        logic [DW-1:0] crc_a; logic [DW-1:0] crc_b;
        logic [15:0] bt_a; logic [15:0] bt_b;
        do_reset();
        fill_pkt(0); fill_pkt(3);
        done0 = 1'b0; viol = 1'b0;
        fork
            begin
                drive_pkt(0, 4, 2, 3, to0);
                done0 = 1'b1;
            end
            drive_pkt(3, 1, -1, 0, to3);
            begin
                for (int c = 0; c < 300 && !done0; c++) begin
                    @(negedge ACLK);
                    if (req_ready[3:1] !== 3'b0) viol = 1'b1;
                end
            end
            begin
                wait_result(0, id_a, crc_a, bt_a, rto_a);
                wait_result(0, id_b, crc_b, bt_b, rto_b);
            end
        join
        n_checks++; if (to0 || to3 || rto_a || rto_b) $display("FAIL stall_timeout: got %b%b%b%b exp 0000", to0, to3, rto_a, rto_b); else n_pass++;
        n_checks++; if (viol) $display("FAIL stall_other_ready: got 1 exp 0"); else n_pass++;
        n_checks++; if ({id_a, crc_a, bt_a} !== {2'd0, model_crc(0, 4), 16'd4}) $display("FAIL stall_result: got %0d/%h/%0d exp 0/%h/4", id_a, crc_a, bt_a, model_crc(0, 4)); else n_pass++;
        n_checks++; if ({id_b, crc_b} !== {2'd3, model_crc(3, 1)}) $display("FAIL stall_next: got %0d/%h exp 3/%h", id_b, crc_b, model_crc(3, 1)); else n_pass++;
    endtask

    task automatic test_hold();
        bit to1; bit to2; bit rto;
        int cyc;
        logic [IW-1:0] gid; logic [DW-1:0] gcrc; logic [15:0] gbeats;
        logic [DW-1:0] e1;
        do_reset();
        fill_pkt(1); fill_pkt(2);
        e1 = model_crc(1, 2);
        fork
            drive_pkt(1, 2, -1, 0, to1);
            drive_pkt(2, 1, -1, 0, to2);
            begin
                cyc = 0;
                while (!res_valid && cyc < 100) begin
                    @(negedge ACLK);
                    cyc++;
                end
                n_checks++; if ({res_valid, res_id, res_crc, res_beats} !== {1'b1, 2'd1, e1, 16'd2}) $display("FAIL hold_first: got %b/%0d/%h/%0d exp 1/1/%h/2", res_valid, res_id, res_crc, res_beats, e1); else n_pass++;
                for (int c = 0; c < 5; c++) begin
                    @(negedge ACLK);
                    n_checks++;
                    if ({res_valid, res_id, res_crc, res_beats, req_ready, busy} !== {1'b1, 2'd1, e1, 16'd2, 4'b0, 1'b1})
                        $display("FAIL hold_stable c=%0d: got %b/%0d/%h/%0d/%b/%b exp 1/1/%h/2/0000/1", c, res_valid, res_id, res_crc, res_beats, req_ready, busy, e1);
                    else n_pass++;
                end
                res_ready = 1'b1;
                @(posedge ACLK);
                @(negedge ACLK);
                res_ready = 1'b0;
                wait_result(0, gid, gcrc, gbeats, rto);
            end
        join
        n_checks++; if (to1 || to2 || rto) $display("FAIL hold_timeout: got %b%b%b exp 000", to1, to2, rto); else n_pass++;
        n_checks++; if ({gid, gcrc} !== {2'd2, model_crc(2, 1)}) $display("FAIL hold_next: got %0d/%h exp 2/%h", gid, gcrc, model_crc(2, 1)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        fill_pkt(0);
        tb_seed[0]  = pkt_seed[0];
        tb_data[0]  = pkt_mem[0][0];
        tb_last[0]  = 1'b0;
        tb_valid[0] = 1'b1;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        tb_data[0] = pkt_mem[0][1];
        n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b exp 1", busy); else n_pass++;
        ARESET      = 1'b1;
        tb_valid[0] = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        n_checks++; if ({busy, res_valid, req_ready} !== 6'b0) $display("FAIL mid_reset_state: got busy=%b valid=%b ready=%b exp 0/0/0000", busy, res_valid, req_ready); else n_pass++;
        n_checks++; if ({crc_initial, res_crc, res_beats} !== 80'h0) $display("FAIL mid_reset_regs: got %h/%h/%h exp 0/0/0", crc_initial, res_crc, res_beats); else n_pass++;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge ACLK);
            if (res_valid) seen = 1'b1;
        end
        n_checks++; if (seen) $display("FAIL mid_no_result: got 1 exp 0"); else n_pass++;
    endtask

    task automatic test_random();
        int ptr_m;
        int order[$];
        logic [NUM_REQ-1:0] mask;
        int len[NUM_REQ];
        int st_at[NUM_REQ];
        int st_len[NUM_REQ];
        bit to[NUM_REQ];
        bit rto;
        logic [IW-1:0] gid; logic [DW-1:0] gcrc; logic [15:0] gbeats;
        do_reset();
        ptr_m = 0;
        for (int it = 0; it < 15; it++) begin
            mask = NUM_REQ'($urandom_range(1, 15));
            order.delete();
            for (int r = 0; r < NUM_REQ; r++) begin
                fill_pkt(r);
                len[r]    = int'($urandom_range(1, 5));
                st_at[r]  = (len[r] > 1) ? int'($urandom_range(1, len[r] - 1)) : -1;
                st_len[r] = int'($urandom_range(0, 2));
                to[r]     = 1'b0;
            end
            for (int k = 0; k < NUM_REQ; k++)
                if (mask[(ptr_m + k) % NUM_REQ]) order.push_back((ptr_m + k) % NUM_REQ);
            ptr_m = (order[order.size() - 1] + 1) % NUM_REQ;
            fork
                begin if (mask[0]) drive_pkt(0, len[0], st_at[0], st_len[0], to[0]); end
                begin if (mask[1]) drive_pkt(1, len[1], st_at[1], st_len[1], to[1]); end
                begin if (mask[2]) drive_pkt(2, len[2], st_at[2], st_len[2], to[2]); end
                begin if (mask[3]) drive_pkt(3, len[3], st_at[3], st_len[3], to[3]); end
                begin
                    for (int j = 0; j < order.size(); j++) begin
                        wait_result(int'($urandom_range(0, 3)), gid, gcrc, gbeats, rto);
                        n_checks++;
                        if (rto) $display("FAIL rand_timeout it=%0d j=%0d: got no result exp id %0d", it, j, order[j]);
                        else n_pass++;
                        n_checks++; if (gid !== IW'(order[j])) $display("FAIL rand_id it=%0d j=%0d: got %0d exp %0d", it, j, gid, order[j]); else n_pass++;
                        n_checks++; if (gcrc !== model_crc(order[j], len[order[j]])) $display("FAIL rand_crc it=%0d j=%0d: got %h exp %h", it, j, gcrc, model_crc(order[j], len[order[j]])); else n_pass++;
                        n_checks++; if (gbeats !== 16'(len[order[j]])) $display("FAIL rand_beats it=%0d j=%0d: got %0d exp %0d", it, j, gbeats, len[order[j]]); else n_pass++;
                    end
                end
            join
            n_checks++; if (to[0] || to[1] || to[2] || to[3]) $display("FAIL rand_drv_timeout it=%0d: got %b%b%b%b exp 0000", it, to[0], to[1], to[2], to[3]); else n_pass++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        ARESET    = 1'b1;
        res_ready = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            tb_valid[r] = 1'b0;
            tb_last[r]  = 1'b0;
            tb_data[r]  = '0;
            tb_seed[r]  = '0;
        end
        test_reset();
        test_basic();
        test_two_req();
        test_single_beat();
        test_stall();
        test_hold();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
